// File: rtl/alu_result_checker.sv
// Purpose: in-harness checker; recomputes each ALU vector's golden result and compares it with the ALU output.
// Latency: a compare fires DUT_LAT cycles after in_valid; counters and done update on the next clock edge.
// Backpressure: none; vectors are sampled only while a run is active, and other traffic is ignored.
module alu_result_checker #(
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [2:0]       sel,
    input  logic             addb,
    input  logic             rightb,
    input  logic             logicb,
    input  logic [31:0]      dut_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      first_err_exp,
    output logic [31:0]      first_err_got
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      fexp_q, fexp_d;
    logic [31:0]      fgot_q, fgot_d;
    logic             busy_q, done_q, pass_q;
    logic [CNT_W-1:0] vec_inc;

    logic [31:0] exp_s;
    logic [4:0]  shamt;
    logic        cmp_vld;
    logic [31:0] cmp_exp;
    logic        mismatch;

    assign shamt = b[4:0];

    // Golden ALU result for the vector currently on the inputs.
    always_comb begin
        exp_s = '0;
        case (sel)
            3'b000: exp_s = addb ? (a - b) : (a + b);
            3'b001,
            3'b101: begin
                if (!rightb)     exp_s = a << shamt;
                else if (logicb) exp_s = a >> shamt;
                else             exp_s = $unsigned($signed(a) >>> shamt);
            end
            3'b010: exp_s = {31'd0, ($signed(a) < $signed(b))};
            3'b011: exp_s = {31'd0, (a < b)};
            3'b100: exp_s = a ^ b;
            3'b110: exp_s = a | b;
            3'b111: exp_s = a & b;
            default: exp_s = '0;
        endcase
    end

    // Alignment of the golden result to the ALU's result latency. Vectors only
    // enter while running; the pipe is flushed whenever the run is not active,
    // which also drops compares still in flight when the run completes.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cmp_vld = in_valid && (state_q == S_RUN);
            assign cmp_exp = exp_s;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_q;
            logic [31:0]        exp_q [DUT_LAT];

            // Shift {valid, expected} one stage per cycle; clear outside a run.
            always_ff @(posedge clk) begin
                if (reset || (state_q != S_RUN)) begin
                    vld_q <= '0;
                    for (int i = 0; i < DUT_LAT; i++) exp_q[i] <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    exp_q[0] <= exp_s;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        exp_q[i] <= exp_q[i-1];
                    end
                end
            end

            assign cmp_vld = vld_q[DUT_LAT-1] && (state_q == S_RUN);
            assign cmp_exp = exp_q[DUT_LAT-1];
        end
    endgenerate

    assign mismatch = (cmp_exp != dut_s);

    // Run control, counting and first-failure capture.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vec_d   = vec_q;
        err_d   = err_q;
        idx_d   = idx_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;
        vec_inc = vec_q + CNT_W'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d   = num_vec;
                    vec_d   = '0;
                    err_d   = '0;
                    idx_d   = '0;
                    fexp_d  = '0;
                    fgot_d  = '0;
                    state_d = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cmp_vld) begin
                    vec_d = vec_inc;
                    if (mismatch) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        if (err_q == '0) begin
                            idx_d  = vec_q;
                            fexp_d = cmp_exp;
                            fgot_d = dut_s;
                        end
                    end
                    if (vec_inc == num_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_d == '0);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_count     = vec_q;
    assign err_count     = err_q;
    assign first_err_idx = idx_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (result latency 0 and 2) share the vector bus.
// Expected run summaries are queued at start; a negedge monitor pops them when done rises.
// Streams are randomized, including gaps, extra vectors after completion and corrupted results.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start2 = 1'b0;
    logic [15:0] num_vec = '0;
    logic        in_valid = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic [2:0]  sel_i = '0;
    logic        addb_i = 1'b0, rightb_i = 1'b0, logicb_i = 1'b0;
    logic [31:0] dut_s0 = '0, dut_s2 = '0;

    logic        busy_w [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic [15:0] vc_w   [2];
    logic [15:0] ec_w   [2];
    logic [15:0] idx_w  [2];
    logic [31:0] fe_w   [2];
    logic [31:0] fg_w   [2];

    always #5 clk = ~clk;

    alu_result_checker #(.DUT_LAT(0), .CNT_W(16)) u_lat0 (
        .clk(clk), .reset(reset), .start(start0), .num_vec(num_vec), .in_valid(in_valid),
        .a(a_i), .b(b_i), .sel(sel_i), .addb(addb_i), .rightb(rightb_i), .logicb(logicb_i),
        .dut_s(dut_s0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .vec_count(vc_w[0]), .err_count(ec_w[0]), .first_err_idx(idx_w[0]),
        .first_err_exp(fe_w[0]), .first_err_got(fg_w[0]));

    alu_result_checker #(.DUT_LAT(2), .CNT_W(16)) u_lat2 (
        .clk(clk), .reset(reset), .start(start2), .num_vec(num_vec), .in_valid(in_valid),
        .a(a_i), .b(b_i), .sel(sel_i), .addb(addb_i), .rightb(rightb_i), .logicb(logicb_i),
        .dut_s(dut_s2), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .vec_count(vc_w[1]), .err_count(ec_w[1]), .first_err_idx(idx_w[1]),
        .first_err_exp(fe_w[1]), .first_err_got(fg_w[1]));

    typedef struct {
        bit          valid;
        logic [31:0] a, b;
        logic [2:0]  sel;
        bit          addb, rightb, logicb;
        logic [31:0] s;       // ALU result presented in this cycle
    } stim_t;

    typedef struct {
        bit          pass;
        int          vc, ec, idx;
        logic [31:0] fe, fg;
        int          done_cyc;
    } res_t;

    stim_t stream[$];
    res_t  sb0[$], sb2[$];
    int    checks = 0, errors = 0;
    int    cyc = 0;
    int    last_done_cyc [2];
    int    last_num_vld_cyc = 0;
    bit    done_prev [2];
    bit    start_prev [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference ALU, written from the function table.
    function automatic logic [31:0] golden(input stim_t e);
        logic [63:0] ext;
        int sa, sb;
        int sh;
        sh = int'(e.b % 32);
        case (e.sel)
            3'd0: return e.addb ? e.a - e.b : e.a + e.b;
            3'd1, 3'd5: begin
                if (!e.rightb) return e.a << sh;
                if (e.logicb) return e.a >> sh;
                ext = {{32{e.a[31]}}, e.a};
                ext = ext >> sh;
                return ext[31:0];
            end
            3'd2: begin
                sa = e.a;
                sb = e.b;
                return (sa < sb) ? 32'd1 : 32'd0;
            end
            3'd3: return (e.a < e.b) ? 32'd1 : 32'd0;
            3'd4: return e.a ^ e.b;
            3'd6: return e.a | e.b;
            default: return e.a & e.b;
        endcase
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? sb0.size() : sb2.size();
    endfunction

    task automatic check_result(input int d);
        res_t r;
        if (qsize(d) == 0) begin
            chk($sformatf("d%0d_unexpected_done", d), 64'd1, 64'd0);
            return;
        end
        r = (d == 0) ? sb0.pop_front() : sb2.pop_front();
        last_done_cyc[d] = cyc;
        chk($sformatf("d%0d_pass", d), pass_w[d], r.pass);
        chk($sformatf("d%0d_vec_count", d), vc_w[d], r.vc);
        chk($sformatf("d%0d_err_count", d), ec_w[d], r.ec);
        chk($sformatf("d%0d_first_err_idx", d), idx_w[d], r.idx);
        chk($sformatf("d%0d_first_err_exp", d), fe_w[d], r.fe);
        chk($sformatf("d%0d_first_err_got", d), fg_w[d], r.fg);
        chk($sformatf("d%0d_done_cycle", d), cyc, r.done_cyc);
    endtask

    // Monitor: a run result is presented when done rises, or stays high across a restart.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset && done_w[d] && (!done_prev[d] || start_prev[d])) check_result(d);
            done_prev[d]  <= done_w[d];
            start_prev[d] <= (d == 0) ? start0 : start2;
        end
    end

    task automatic add(input bit v, input logic [31:0] a_, input logic [31:0] b_, input logic [2:0] s_,
                       input bit ad, input bit rb, input bit lb, input logic [31:0] res);
        stim_t e;
        e.valid = v; e.a = a_; e.b = b_; e.sel = s_;
        e.addb = ad; e.rightb = rb; e.logicb = lb; e.s = res;
        stream.push_back(e);
    endtask

    task automatic add_random(input bit v);
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = ($urandom_range(7) == 0) ? ra : $urandom;
        add(v, ra, rb, 3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), $urandom);
    endtask

    // Result the ALU presents in cycle t: golden of the vector lat cycles earlier, maybe corrupted.
    task automatic assign_s(input int lat, input int corrupt_pct);
        logic [31:0] g;
        for (int t = 0; t < stream.size(); t++) begin
            if (t >= lat && stream[t-lat].valid) begin
                g = golden(stream[t-lat]);
                if ($urandom_range(99) < corrupt_pct) g = g ^ (32'd1 << $urandom_range(31));
                stream[t].s = g;
            end else begin
                stream[t].s = $urandom;
            end
        end
    endtask

    task automatic build_random(input int lat, input int nvalid, input int gap_pct, input int corrupt_pct);
        stream.delete();
        for (int i = 0; i < nvalid; i++) begin
            if ($urandom_range(99) < gap_pct) add_random(1'b0);
            add_random(1'b1);
        end
        for (int i = 0; i < 4; i++) add_random(1'b0);
        assign_s(lat, corrupt_pct);
    endtask

    task automatic drive_elem(input stim_t e);
        in_valid = e.valid; a_i = e.a; b_i = e.b; sel_i = e.sel;
        addb_i = e.addb; rightb_i = e.rightb; logicb_i = e.logicb;
    endtask

    task automatic run_stream(input int d, input int num, input int mid_at);
        int lat, cnt, last_t, s_cyc;
        logic [31:0] e, g;
        res_t r;
        stim_t junk;
        lat = (d == 0) ? 0 : 2;
        cnt = 0;
        last_t = -1;
        r = '{pass: 1'b1, vc: 0, ec: 0, idx: 0, fe: 32'd0, fg: 32'd0, done_cyc: 0};
        for (int t = 0; t < stream.size(); t++) begin
            if (stream[t].valid && cnt < num) begin
                e = golden(stream[t]);
                g = stream[t+lat].s;
                if (e !== g) begin
                    if (r.ec == 0) begin r.idx = cnt; r.fe = e; r.fg = g; end
                    r.ec++;
                end
                cnt++;
                last_t = t;
            end
        end
        r.pass = (r.ec == 0);
        r.vc = cnt;

        @(posedge clk); #1;
        s_cyc = cyc;
        junk.valid = 1'b1; junk.a = $urandom; junk.b = $urandom; junk.sel = 3'($urandom_range(7));
        junk.addb = 1'b0; junk.rightb = 1'b0; junk.logicb = 1'b0; junk.s = '0;
        drive_elem(junk);                  // the start cycle's vector must be ignored
        num_vec = 16'(num);
        if (d == 0) start0 = 1'b1; else start2 = 1'b1;
        dut_s0 = $urandom; dut_s2 = $urandom;
        r.done_cyc = (num == 0) ? s_cyc + 1 : s_cyc + 2 + last_t + lat;
        last_num_vld_cyc = s_cyc + 1 + last_t;
        if (d == 0) sb0.push_back(r); else sb2.push_back(r);

        for (int t = 0; t < stream.size(); t++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start2 = 1'b0;
            num_vec = 16'($urandom);
            if (t == mid_at) begin
                num_vec = 16'(num + 5);
                if (d == 0) start0 = 1'b1; else start2 = 1'b1;
            end
            drive_elem(stream[t]);
            if (d == 0) begin dut_s0 = stream[t].s; dut_s2 = $urandom; end
            else        begin dut_s2 = stream[t].s; dut_s0 = $urandom; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start0 = 1'b0; start2 = 1'b0;

        for (int i = 0; i < 30 && qsize(d) != 0; i++) @(negedge clk);
        chk($sformatf("d%0d_sb_drained", d), qsize(d), 0);
        if (d == 0) sb0.delete(); else sb2.delete();
        @(negedge clk);
        chk($sformatf("d%0d_done_held", d), done_w[d], 1);
        chk($sformatf("d%0d_vec_count_held", d), vc_w[d], num);
    endtask

    initial begin
        int nvalid, num;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_reset_outputs", d),
                {busy_w[d], done_w[d], pass_w[d], vc_w[d], ec_w[d], idx_w[d]}, 64'd0);
            chk($sformatf("d%0d_reset_first_err", d), {fe_w[d], fg_w[d]}, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Add then subtract, both correct.
        stream.delete();
        add(1, 32'd5, 32'd3, 3'b000, 0, 0, 0, 32'd8);
        add(1, 32'd5, 32'd3, 3'b000, 1, 0, 0, 32'd2);
        repeat (3) add_random(1'b0);
        run_stream(0, 2, -1);
        chk("add_sub_pass", pass_w[0], 1);
        chk("add_sub_err_count", ec_w[0], 0);
        chk("lat0_done_delay", last_done_cyc[0] - last_num_vld_cyc, 1);

        // Arithmetic vs logical right shift, then a wrong answer for the arithmetic one.
        stream.delete();
        add(1, 32'h8000_0000, 32'd4, 3'b101, 0, 1, 0, 32'hF800_0000);
        add(1, 32'h8000_0000, 32'd4, 3'b101, 0, 1, 1, 32'h0800_0000);
        add(1, 32'h8000_0000, 32'd4, 3'b101, 0, 1, 0, 32'h0800_0000);
        repeat (3) add_random(1'b0);
        run_stream(0, 3, -1);
        chk("sra_err_count", ec_w[0], 1);
        chk("sra_first_err_exp", fe_w[0], 32'hF800_0000);
        chk("sra_first_err_idx", idx_w[0], 2);

        // Signed vs unsigned set-less-than, wrong unsigned answer.
        stream.delete();
        add(1, 32'hFFFF_FFFF, 32'd1, 3'b010, 0, 0, 0, 32'd1);
        add(1, 32'hFFFF_FFFF, 32'd1, 3'b011, 0, 0, 0, 32'd1);
        repeat (3) add_random(1'b0);
        run_stream(0, 2, -1);
        chk("slt_first_err_idx", idx_w[0], 1);
        chk("slt_first_err_got", fg_w[0], 1);
        chk("slt_pass", pass_w[0], 0);

        // Two-cycle ALU, results delayed correctly, then the same stream undelayed.
        build_random(2, 3, 0, 0);
        run_stream(1, 3, -1);
        chk("lat2_pass", pass_w[1], 1);
        chk("lat2_done_delay", last_done_cyc[1] - last_num_vld_cyc, 3);
        assign_s(0, 0);
        run_stream(1, 3, -1);
        chk("lat2_undelayed_errs", ec_w[1] != 16'd0, 1);

        // Reset in the middle of a run.
        build_random(0, 6, 0, 0);
        @(posedge clk); #1;
        num_vec = 16'd5; start0 = 1'b1; in_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            drive_elem(stream[t]);
            dut_s0 = stream[t].s;
        end
        @(negedge clk);
        chk("busy_before_reset", busy_w[0], 1);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_reset_status", {busy_w[0], done_w[0], pass_w[0]}, 0);
        chk("midrun_reset_counts", {vc_w[0], ec_w[0], idx_w[0]}, 0);
        chk("midrun_reset_first_err", {fe_w[0], fg_w[0]}, 0);

        // Empty run completes on the next cycle.
        stream.delete();
        repeat (3) add_random(1'b0);
        run_stream(0, 0, -1);
        chk("empty_run_pass", pass_w[0], 1);

        // Start while running is ignored.
        build_random(0, 6, 20, 30);
        run_stream(0, 5, 2);
        build_random(2, 6, 20, 30);
        run_stream(1, 5, 2);

        // Randomized runs with gaps, corruption and surplus vectors.
        for (int r = 0; r < 16; r++) begin
            nvalid = $urandom_range(1, 8);
            num = $urandom_range(0, nvalid);
            build_random((r % 2 == 0) ? 0 : 2, nvalid, 25, 30);
            run_stream(r % 2, num, -1);
        end

        chk("sb0_empty", sb0.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
